muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/muldiv_ctrl_if.sv | 33 +++
 rtl/muldiv_ctrl_div_iter.sv | 54 +++++
 rtl/muldiv_ctrl.sv | 161 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op and state encodings, default widths.
package muldiv_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline <-> muldiv request/result bundle.
// master = pipeline side, slave = muldiv_ctrl.
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic [DATA_W-1:0] hi_rd_data;
  logic [DATA_W-1:0] lo_rd_data;
  logic              ready;
  logic              stall;
  logic              hilo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;
  logic              done;

  modport master (
    output start, op, src_a, src_b, flush,
    output hi_rd_data, lo_rd_data,
    input  ready, stall, hilo_we,
    input  hi_wdata, lo_wdata, done
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    input  hi_rd_data, lo_rd_data,
    output ready, stall, hilo_we,
    output hi_wdata, lo_wdata, done
  );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider on magnitudes, one quotient bit per cycle,
// DATA_W steps after start.
module div_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] quo, rem, dvs;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   shifted, diff;

  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      // keep the trial difference only if it did not borrow
      if (!diff[DATA_W]) begin
        rem <= diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b1};
      end else begin
        rem <= shifted[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer. Define MULDIV_FAST_MUL_EN
// for a single-cycle MULT/MULTU; default is shift-add.
module muldiv_ctrl #(
  parameter int DATA_W = muldiv_ctrl_pkg::DATA_W,
  parameter int CNT_W  = muldiv_ctrl_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_ctrl_if.slave   bus
);
  import muldiv_ctrl_pkg::*;

  localparam int W = DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_e state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   prod, prod_step, mul_res;
  logic [W:0]       add_hi;
  logic [W-1:0]     mcand, res_hi, res_lo;
  logic             neg_q, neg_r, use_div;

  logic is_signed, is_mul, is_div, b_zero;
  logic a_neg, b_neg, accept, div_start;
  logic [W-1:0] a_mag, b_mag;
  logic         div_busy;
  logic [W-1:0] div_q, div_r, q_fix, r_fix;

  assign is_signed = bus.op == OP_MULT || bus.op == OP_DIV;
  assign is_mul    = bus.op == OP_MULT || bus.op == OP_MULTU;
  assign is_div    = bus.op == OP_DIV  || bus.op == OP_DIVU;
  assign b_zero    = bus.src_b == '0;
  assign a_neg     = is_signed & bus.src_a[W-1];
  assign b_neg     = is_signed & bus.src_b[W-1];
  assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag     = b_neg ? -bus.src_b : bus.src_b;

  assign accept = state == S_IDLE && bus.start &&
                  !bus.flush && op_valid(bus.op);
  assign div_start = accept && is_div && !b_zero;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod, fast_res;
  assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
  assign fast_res  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif

  // shift-add: multiplier sits in the low half and drains out
  assign add_hi    = {1'b0, prod[2*W-1:W]} +
                     (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {add_hi, prod[W-1:1]};
  assign mul_res   = neg_q ? -prod_step : prod_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            state_nx = S_DONE;
`else
            state_nx = S_MUL;
`endif
          end else if (is_div && !b_zero) begin
            state_nx = S_DIV;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush)          state_nx = S_IDLE;
        else if (cnt == LAST)   state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      use_div <= 1'b0;
      res_hi  <= '0;
      res_lo  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      mcand   <= a_mag;
      prod    <= {{W{1'b0}}, b_mag};
      use_div <= is_div && !b_zero;
      unique case (1'b1)
        is_mul: begin
`ifdef MULDIV_FAST_MUL_EN
          {res_hi, res_lo} <= fast_res;
`endif
        end
        is_div: begin
          if (b_zero) begin
            res_hi <= bus.src_a;
            res_lo <= '1;
          end
        end
        bus.op == OP_MTHI: begin
          res_hi <= bus.src_a;
          res_lo <= bus.lo_rd_data;
        end
        bus.op == OP_MTLO: begin
          res_hi <= bus.hi_rd_data;
          res_lo <= bus.src_a;
        end
        default: ;
      endcase
    end else if (state == S_MUL || state == S_DIV) begin
      cnt <= (bus.flush || cnt == LAST) ? '0 : cnt + 1'b1;
      if (state == S_MUL && !bus.flush) begin
        prod <= prod_step;
        if (cnt == LAST) {res_hi, res_lo} <= mul_res;
      end
    end
  end

  div_iter #(
    .DATA_W (W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign q_fix = neg_q ? -div_q : div_q;
  assign r_fix = neg_r ? -div_r : div_r;

  assign bus.ready    = state == S_IDLE;
  assign bus.done     = state == S_DONE;
  assign bus.hilo_we  = state == S_DONE;
  assign bus.stall    = accept || state == S_MUL ||
                        state == S_DIV;
  assign bus.hi_wdata = use_div ? r_fix : res_hi;
  assign bus.lo_wdata = use_div ? q_fix : res_lo;

  logic unused;
  assign unused = div_busy;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with an arithmetic
// reference model and literal expectations.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.DATA_W(32)) bus();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] hr,
    input logic [31:0] lr);
    logic [63:0] r;
    int sa, sb;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      3'd0: r = 64'(longint'(sa) * longint'(sb));
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          r = {32'h0, 32'h80000000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      3'd4: r = {a, lr};
      3'd5: r = {hr, a};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [2:0] op,
                             input logic [31:0] b);
    if (op <= 3'd1) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if ((op == 3'd2 || op == 3'd3) && b != 0) return 33;
    return 1;
  endfunction

  logic        pending = 1'b0;
  int          elapsed = 0;
  int          exp_lat = 0;
  int          we_cnt  = 0;
  logic [31:0] exp_hi, exp_lo, got_hi, got_lo;

  always @(negedge clk) begin
    if (bus.hilo_we) we_cnt++;
    if (pending) begin
      elapsed++;
      chk("done_timing", 64'(bus.done), 64'(elapsed == exp_lat));
      chk("we_eq_done", 64'(bus.hilo_we), 64'(bus.done));
      chk("ready_busy", 64'(bus.ready), 64'(0));
      chk("stall_busy", 64'(bus.stall), 64'(elapsed != exp_lat));
      if (elapsed >= exp_lat) begin
        chk("model_hi", 64'(bus.hi_wdata), 64'(exp_hi));
        chk("model_lo", 64'(bus.lo_wdata), 64'(exp_lo));
        got_hi  = bus.hi_wdata;
        got_lo  = bus.lo_wdata;
        pending = 1'b0;
      end
    end else if (rst) begin
      chk("idle_no_we", 64'(bus.hilo_we), 64'(0));
      chk("idle_no_done", 64'(bus.done), 64'(0));
    end
  end

  task automatic accept_op(input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [31:0] hr,
                           input logic [31:0] lr);
    @(posedge clk); #1;
    bus.op = op; bus.src_a = a; bus.src_b = b;
    bus.hi_rd_data = hr; bus.lo_rd_data = lr;
    bus.start = 1'b1;
    #1 chk("stall_req", 64'(bus.stall), 64'(1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 3'd7;
    bus.src_a = $urandom; bus.src_b = $urandom;
    bus.hi_rd_data = $urandom; bus.lo_rd_data = $urandom;
    {exp_hi, exp_lo} = model(op, a, b, hr, lr);
    exp_lat = lat(op, b);
    elapsed = 0;
    we_cnt  = 0;
    pending = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] hr,
                        input logic [31:0] lr,
                        input logic [31:0] lit_hi,
                        input logic [31:0] lit_lo);
    accept_op(op, a, b, hr, lr);
    wait (!pending);
    repeat (3) @(negedge clk);
    chk("we_pulses", 64'(we_cnt), 64'(1));
    chk("lit_hi", 64'(got_hi), 64'(lit_hi));
    chk("lit_lo", 64'(got_lo), 64'(lit_lo));
    chk("ready_after", 64'(bus.ready), 64'(1));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hr, lr, hi, lo;
  } vec_t;

  vec_t vecs[$] = '{
    '{3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1},
    '{3'd0, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0},
    '{3'd1, 32'h0, 32'd12345, 0, 0, 32'h0, 32'h0},
    '{3'd3, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14},
    '{3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000},
    '{3'd2, 32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD},
    '{3'd3, 32'hFFFFFFFF, 32'd1, 0, 0, 32'h0, 32'hFFFFFFFF},
    '{3'd3, 32'd3, 32'd10, 0, 0, 32'd3, 32'h0},
    '{3'd2, 32'h1234, 32'h0, 0, 0, 32'h1234, 32'hFFFFFFFF},
    '{3'd3, 32'd5, 32'h0, 0, 0, 32'd5, 32'hFFFFFFFF},
    '{3'd5, 32'hA5A5A5A5, 0, 32'h11, 32'h22, 32'h11, 32'hA5A5A5A5},
    '{3'd4, 32'hDEADBEEF, 0, 32'h33, 32'h55, 32'hDEADBEEF, 32'h55}
  };

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.flush = 1'b0;
    bus.src_a = '0; bus.src_b = '0;
    bus.hi_rd_data = '0; bus.lo_rd_data = '0;
    #2;
    chk("rst_ready", 64'(bus.ready), 64'(1));
    chk("rst_we", 64'(bus.hilo_we), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_hi", 64'(bus.hi_wdata), 64'(0));
    chk("rst_lo", 64'(bus.lo_wdata), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hr, vecs[i].lr, vecs[i].hi, vecs[i].lo);

    // reserved opcode: no stall, no state change, no write
    @(posedge clk); #1;
    bus.op = 3'd6; bus.start = 1'b1; we_cnt = 0;
    #1 chk("rsv_stall", 64'(bus.stall), 64'(0));
    @(posedge clk); #1 bus.start = 1'b0;
    chk("rsv_ready", 64'(bus.ready), 64'(1));
    repeat (5) @(negedge clk);
    chk("rsv_no_we", 64'(we_cnt), 64'(0));

    // flush together with start in IDLE drops the start
    @(posedge clk); #1;
    bus.op = 3'd3; bus.src_a = 32'd9; bus.src_b = 32'd2;
    bus.start = 1'b1; bus.flush = 1'b1; we_cnt = 0;
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    chk("fs_ready", 64'(bus.ready), 64'(1));
    repeat (40) @(negedge clk);
    chk("fs_no_we", 64'(we_cnt), 64'(0));

    // flush mid-division
    accept_op(3'd3, 32'd100, 32'd7, 0, 0);
    repeat (9) @(posedge clk);
    #1 pending = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("fl_ready", 64'(bus.ready), 64'(1));
    chk("fl_stall", 64'(bus.stall), 64'(0));
    repeat (40) @(negedge clk);
    chk("fl_no_we", 64'(we_cnt), 64'(0));
    chk("fl_idle", 64'(bus.ready), 64'(1));

    // async reset mid-MULTU
    accept_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    repeat (19) @(posedge clk);
    #2 pending = 1'b0; rst = 1'b0;
    #1;
    chk("ar_we", 64'(bus.hilo_we), 64'(0));
    chk("ar_done", 64'(bus.done), 64'(0));
    chk("ar_hi", 64'(bus.hi_wdata), 64'(0));
    chk("ar_lo", 64'(bus.lo_wdata), 64'(0));
    chk("ar_ready", 64'(bus.ready), 64'(1));
    @(posedge clk); #1 rst = 1'b1; we_cnt = 0;
    repeat (40) @(negedge clk);
    chk("ar_no_we", 64'(we_cnt), 64'(0));
    chk("ar_idle", 64'(bus.ready), 64'(1));

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0,
           32'hFFFFFFFF, 32'hFFFFFFFA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
